// File: rtl/digital_clock_core.sv
// rtl/digital_clock_core.sv - 1 Hz prescaled BCD time-of-day core with set autorepeat, 12/24h display and HH:MM alarm
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ena               advance prescaler and time when high
//   i_mode_12h        1 = 12-hour display mapping, 0 = 24-hour
//   i_set_hours       level; increments the hours target (autorepeat while held)
//   i_set_minutes     level; increments the minutes target (autorepeat while held)
//   i_set_alarm       set inputs and display target the alarm registers
//   i_alarm_en        arms the alarm compare
//   o_hours/o_minutes/o_seconds  BCD display of the selected source
//   o_pm              displayed hour >= 12
//   o_tick            one-cycle pulse on each prescaler wrap
//   o_alarm           registered alarm match

module digital_clock_core #(
    parameter int CLK_HZ = 10_000_000,
    parameter int SET_HZ = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       i_mode_12h,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    input  logic       i_set_alarm,
    input  logic       i_alarm_en,
    output logic [7:0] o_hours,
    output logic [7:0] o_minutes,
    output logic [7:0] o_seconds,
    output logic       o_pm,
    output logic       o_tick,
    output logic       o_alarm
);

    localparam int REP_P = CLK_HZ / SET_HZ;
    localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW    = (REP_P > 1) ? $clog2(REP_P) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_P - 1);

    logic [PW-1:0] presc;
    logic [RW-1:0] rep_cnt;
    logic [7:0]    sec;
    logic [7:0]    min;
    logic [7:0]    hr;
    logic [7:0]    a_min;
    logic [7:0]    a_hr;
    logic          prev_h;
    logic          prev_m;
    logic          arm_h;
    logic          arm_m;
    logic          alarm_q;

    logic          rise_h;
    logic          rise_m;
    logic          stb_h;
    logic          stb_m;
    logic          time_set;
    logic          tick;
    logic [7:0]    disp_h;
    logic [7:0]    disp_m;

    // BCD increment that wraps to 00 after the given terminal value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // 24h BCD hour to 12h BCD hour: 00 -> 12, 13..23 -> 01..11.
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        logic [4:0] b;
        logic [7:0] r;
        b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
        if (h == 8'h00)
            r = 8'h12;
        else if (h <= 8'h12)
            r = h;
        else begin
            b = b - 5'd12;
            r = (b >= 5'd10) ? {4'd1, 4'(b - 5'd10)} : {4'd0, b[3:0]};
        end
        return r;
    endfunction

    // Strobes: immediate on a press, then every REP_P cycles while held.
    // The arm flags stop a level that was already high out of reset from
    // autorepeating; it must be released and pressed again.
    always_comb begin
        rise_h   = i_set_hours & ~prev_h;
        rise_m   = i_set_minutes & ~prev_m;
        stb_h    = rise_h | (arm_h & i_set_hours & (rep_cnt == REP_MAX));
        stb_m    = rise_m | (arm_m & i_set_minutes & (rep_cnt == REP_MAX));
        time_set = (stb_h | stb_m) & ~i_set_alarm;
        tick     = ena & (presc == PRE_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h  <= 1'b1;
            prev_m  <= 1'b1;
            arm_h   <= 1'b0;
            arm_m   <= 1'b0;
            rep_cnt <= '0;
        end else begin
            prev_h <= i_set_hours;
            prev_m <= i_set_minutes;
            arm_h  <= i_set_hours & (arm_h | rise_h);
            arm_m  <= i_set_minutes & (arm_m | rise_m);
            // One shared counter so simultaneously held inputs repeat together.
            if (rise_h | rise_m)
                rep_cnt <= '0;
            else if ((arm_h & i_set_hours) | (arm_m & i_set_minutes))
                rep_cnt <= (rep_cnt == REP_MAX) ? '0 : rep_cnt + RW'(1);
            else
                rep_cnt <= '0;
        end
    end

    // Timekeeping: a time-set strobe overrides a coincident tick entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            sec   <= 8'h00;
            min   <= 8'h00;
            hr    <= 8'h00;
        end else if (time_set) begin
            presc <= '0;
            sec   <= 8'h00;
            if (stb_h)
                hr <= bcd_inc(hr, 8'h23);
            if (stb_m)
                min <= bcd_inc(min, 8'h59);
        end else if (ena) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                sec <= bcd_inc(sec, 8'h59);
                if (sec == 8'h59) begin
                    min <= bcd_inc(min, 8'h59);
                    if (min == 8'h59)
                        hr <= bcd_inc(hr, 8'h23);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_min   <= 8'h00;
            a_hr    <= 8'h00;
            alarm_q <= 1'b0;
        end else begin
            if (i_set_alarm && stb_h)
                a_hr <= bcd_inc(a_hr, 8'h23);
            if (i_set_alarm && stb_m)
                a_min <= bcd_inc(a_min, 8'h59);
            alarm_q <= i_alarm_en & (hr == a_hr) & (min == a_min);
        end
    end

    always_comb begin
        disp_h    = i_set_alarm ? a_hr : hr;
        disp_m    = i_set_alarm ? a_min : min;
        o_hours   = i_mode_12h ? to_12h(disp_h) : disp_h;
        o_minutes = disp_m;
        o_seconds = i_set_alarm ? 8'h00 : sec;
        o_pm      = (disp_h >= 8'h12);
        o_tick    = tick;
        o_alarm   = alarm_q;
    end

endmodule

// File: tb/tb_digital_clock_core.sv
// tb/tb_digital_clock_core.sv - directed self-checking bench for digital_clock_core (CLK_HZ=10, SET_HZ=2)

module tb_digital_clock_core;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       i_mode_12h;
    logic       i_set_hours;
    logic       i_set_minutes;
    logic       i_set_alarm;
    logic       i_alarm_en;
    logic [7:0] o_hours;
    logic [7:0] o_minutes;
    logic [7:0] o_seconds;
    logic       o_pm;
    logic       o_tick;
    logic       o_alarm;

    int checks   = 0;
    int failures = 0;

    digital_clock_core #(.CLK_HZ(10), .SET_HZ(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .i_mode_12h    (i_mode_12h),
        .i_set_hours   (i_set_hours),
        .i_set_minutes (i_set_minutes),
        .i_set_alarm   (i_set_alarm),
        .i_alarm_en    (i_alarm_en),
        .o_hours       (o_hours),
        .o_minutes     (o_minutes),
        .o_seconds     (o_seconds),
        .o_pm          (o_pm),
        .o_tick        (o_tick),
        .o_alarm       (o_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        check({tag, "_hours"}, o_hours, h);
        check({tag, "_minutes"}, o_minutes, m);
        check({tag, "_seconds"}, o_seconds, s);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_h(input int n);
        repeat (n) begin
            i_set_hours = 1'b1;
            @(negedge clk);
            i_set_hours = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press_m(input int n);
        repeat (n) begin
            i_set_minutes = 1'b1;
            @(negedge clk);
            i_set_minutes = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        ena           = 1'b0;
        i_mode_12h    = 1'b0;
        i_set_hours   = 1'b0;
        i_set_minutes = 1'b0;
        i_set_alarm   = 1'b0;
        i_alarm_en    = 1'b0;

        // reset state
        run(2);
        check_time("rst24", 8'h00, 8'h00, 8'h00);
        check("rst_pm", 8'(o_pm), 8'h00);
        check("rst_tick", 8'(o_tick), 8'h00);
        check("rst_alarm", 8'(o_alarm), 8'h00);
        i_mode_12h = 1'b1;
        #1;
        check("rst12_hours", o_hours, 8'h12);
        @(negedge clk);
        rst_n = 1'b1;
        run(1);

        // 12-hour mapping
        press_h(11);
        check("h11_hours", o_hours, 8'h11);
        check("h11_pm", 8'(o_pm), 8'h00);
        press_h(1);
        check("h12_hours", o_hours, 8'h12);
        check("h12_pm", 8'(o_pm), 8'h01);
        press_h(1);
        check("h13_hours", o_hours, 8'h01);
        check("h13_pm", 8'(o_pm), 8'h01);
        press_h(10);
        check("h23_hours", o_hours, 8'h11);
        check("h23_pm", 8'(o_pm), 8'h01);
        i_mode_12h = 1'b0;
        #1;
        check("h23_24h", o_hours, 8'h23);
        @(negedge clk);
        press_h(1);
        check("hwrap_hours", o_hours, 8'h00);
        check("hwrap_pm", 8'(o_pm), 8'h00);

        // midnight rollover with 1 Hz ticks
        press_h(23);
        press_m(59);
        check_time("set2359", 8'h23, 8'h59, 8'h00);
        ena = 1'b1;
        run(580);
        check_time("t235958", 8'h23, 8'h59, 8'h58);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("tick_k%0d", k), 8'(o_tick), (k % 10 == 9) ? 8'h01 : 8'h00);
            if (k == 10) check_time("t235959", 8'h23, 8'h59, 8'h59);
            if (k == 20) begin
                check_time("t000000", 8'h00, 8'h00, 8'h00);
                check("t000000_pm", 8'(o_pm), 8'h00);
            end
        end

        // minutes autorepeat from 10:58:33, P=5
        ena = 1'b0;
        press_h(10);
        press_m(58);
        ena = 1'b1;
        run(330);
        check_time("t105833", 8'h10, 8'h58, 8'h33);
        i_set_minutes = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            check($sformatf("rep_min_e%0d", j), o_minutes,
                  (j < 6) ? 8'h59 : ((j < 11) ? 8'h00 : 8'h01));
        end
        check("rep_hours", o_hours, 8'h10);
        check("rep_seconds", o_seconds, 8'h00);
        i_set_minutes = 1'b0;

        // minutes set coinciding with a tick at 12:00:59
        ena = 1'b0;
        press_h(2);
        press_m(59);
        ena = 1'b1;
        run(590);
        check_time("t120059", 8'h12, 8'h00, 8'h59);
        run(9);
        check("coin_tick", 8'(o_tick), 8'h01);
        i_set_minutes = 1'b1;
        @(negedge clk);
        i_set_minutes = 1'b0;
        check_time("coin_set", 8'h12, 8'h01, 8'h00);
        run(8);
        check("coin_presc8", 8'(o_tick), 8'h00);
        run(1);
        check("coin_presc9", 8'(o_tick), 8'h01);
        run(1);
        check("coin_sec01", o_seconds, 8'h01);

        // alarm 07:30
        ena = 1'b0;
        i_set_alarm = 1'b1;
        press_h(7);
        press_m(30);
        check_time("alarm_disp", 8'h07, 8'h30, 8'h00);
        check("alarm_disp_pm", 8'(o_pm), 8'h00);
        i_set_alarm = 1'b0;
        press_h(19);
        press_m(28);
        check_time("t072900", 8'h07, 8'h29, 8'h00);
        i_alarm_en = 1'b1;
        ena = 1'b1;
        run(590);
        check_time("t072959", 8'h07, 8'h29, 8'h59);
        check("alarm_before", 8'(o_alarm), 8'h00);
        run(10);
        check("t073000_min", o_minutes, 8'h30);
        check("alarm_lag", 8'(o_alarm), 8'h00);
        run(1);
        check("alarm_rise", 8'(o_alarm), 8'h01);
        i_alarm_en = 1'b0;
        run(1);
        check("alarm_clear", 8'(o_alarm), 8'h00);

        // asynchronous reset while hours is held
        ena = 1'b0;
        i_set_hours = 1'b1;
        @(negedge clk);
        check("hold_hours", o_hours, 8'h08);
        run(3);
        #2 rst_n = 1'b0;
        #1;
        check_time("async_rst", 8'h00, 8'h00, 8'h00);
        check("async_rst_alarm", 8'(o_alarm), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(12);
        check("held_after_rst", o_hours, 8'h00);
        i_set_hours = 1'b0;
        run(1);
        press_h(1);
        check("repress_hours", o_hours, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
